// File: rtl/multicycle_accum_seq.sv
// Multicycle add/subtract sequencer: loads op[0], then accumulates op[1..NUM_OPS-1] one per clock
// through a single shared adder; reports result, last carry/not-borrow and sticky overflow.
module multicycle_accum_seq #(
    parameter  int WIDTH   = 8,
    parameter  int NUM_OPS = 4,
    localparam int IDX_W   = $clog2(NUM_OPS) + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [NUM_OPS*WIDTH-1:0]   op_data,
    input  logic [NUM_OPS-1:0]         sub_mask,
    output logic                       busy,
    output logic                       done,
    output logic [WIDTH-1:0]           result,
    output logic                       carry_out,
    output logic                       ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [NUM_OPS*WIDTH-1:0]   ops_q;
    logic [NUM_OPS-1:0]         mask_q;
    logic [WIDTH-1:0]           acc_q;
    logic [IDX_W-1:0]           idx_q;

    logic                       accept;
    logic                       last;
    logic [WIDTH-1:0]           cur_op;
    logic                       cur_sub;
    logic [WIDTH-1:0]           addend;
    logic [WIDTH-1:0]           sum;
    logic                       sum_c;
    logic                       step_ovf;

    assign accept = start && (state_q != ACCUM);
    assign last   = (idx_q == IDX_W'(NUM_OPS - 1));
    assign busy   = (state_q == ACCUM);
    assign done   = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = (NUM_OPS > 1) ? ACCUM : DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand mux over the captured copies; idx never selects op[0] while accumulating.
    always_comb begin
        cur_op  = '0;
        cur_sub = 1'b0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_op  = ops_q[i*WIDTH +: WIDTH];
                cur_sub = mask_q[i];
            end
        end
    end

    // Subtraction is acc + ~op + 1, so carry_out reads as not-borrow.
    always_comb begin
        addend          = cur_sub ? ~cur_op : cur_op;
        {sum_c, sum}    = {1'b0, acc_q} + {1'b0, addend} + {{WIDTH{1'b0}}, cur_sub};
        step_ovf        = (acc_q[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != acc_q[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ops_q     <= '0;
            mask_q    <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            ovf       <= 1'b0;
        end else if (accept) begin
            ops_q     <= op_data;
            mask_q    <= sub_mask;
            acc_q     <= op_data[WIDTH-1:0];
            idx_q     <= IDX_W'(1);
            carry_out <= 1'b0;
            ovf       <= 1'b0;
            if (NUM_OPS == 1) begin
                result <= op_data[WIDTH-1:0];
            end
        end else if (state_q == ACCUM) begin
            acc_q     <= sum;
            carry_out <= sum_c;
            ovf       <= ovf | step_ovf;
            idx_q     <= idx_q + IDX_W'(1);
            if (last) begin
                result <= sum;
            end
        end
    end

endmodule
